poseidon_word_packer: RTL and testbench

Host-side transmitter for the Poseidon hashing core's element input stream. It accepts a 64-bit valid/ready/last host stream and packs four consecutive words, little-endian, into one 256-bit field-element beat. It drives the core's `io_input_*` port with `io_output_*` and preserves message boundaries through `last`. Partial trailing elements are zero-padded.

---
 rtl/poseidon_pkg.sv | 26 ++
 rtl/poseidon_modulus_check.sv | 17 +
 rtl/poseidon_word_packer.sv | 156 +++++++++++++++
 tb/tb_poseidon_word_packer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/poseidon_pkg.sv
// poseidon_pkg
// Shared constants and types for the Poseidon host-side word packer.
//   HOST_W           : host word width (64)
//   ELEM_W           : packed field-element width (256)
//   WORDS            : host words per element (4)
//   POSEIDON_MODULUS : BLS12-381 scalar field modulus (255 bits)
//   elem_t / word_t  : element and host word types
//   packer_state_t   : COLLECT (no beat pending) / OFFER (beat pending)
package poseidon_pkg;

    localparam int HOST_W = 64;
    localparam int ELEM_W = 256;
    localparam int WORDS  = 4;

    localparam logic [254:0] POSEIDON_MODULUS =
        255'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001;

    typedef logic [ELEM_W-1:0] elem_t;
    typedef logic [HOST_W-1:0] word_t;

    typedef enum logic {
        COLLECT = 1'b0,
        OFFER   = 1'b1
    } packer_state_t;

endpackage

// File: rtl/poseidon_modulus_check.sv
// poseidon_modulus_check
// Combinational range check of a packed field element against the
// BLS12-381 scalar field modulus.
//   i_elem : 256-bit element (little-endian packed host words)
//   o_ge   : 1 when i_elem >= POSEIDON_MODULUS (element out of field)
module poseidon_modulus_check
    import poseidon_pkg::*;
(
    input  elem_t i_elem,
    output logic  o_ge
);

    // The modulus is 255 bits; widen with a zero MSB so any element with
    // bit 255 set is correctly flagged as out of field.
    assign o_ge = (i_elem >= {1'b0, POSEIDON_MODULUS});

endmodule

// File: rtl/poseidon_word_packer.sv
// poseidon_word_packer
// Packs four consecutive 64-bit host words (little-endian, word 0 in the
// LSBs) into one 256-bit field-element beat for the Poseidon core input.
// Message boundaries are carried through 'last'; a short trailing element
// is zero-padded in its upper slots.
//
// Optional feature: define POSEIDON_FIELD_CHECK_EN to build a sticky
// out-of-field flag (io_error) that sets when a completing element is
// >= the BLS12-381 scalar modulus. The element is forwarded regardless.
//
// Ports:
//   clk               : clock, rising edge
//   reset             : asynchronous reset, active low
//   io_host_valid     : host word valid
//   io_host_ready     : packer can take a host word
//   io_host_last      : last host word of the message
//   io_host_payload   : host word
//   io_output_valid   : element beat valid (to core io_input_valid)
//   io_output_ready   : core accepts the beat
//   io_output_last    : last element of the message
//   io_output_payload : packed element, slot k at [64k+63:64k]
//   io_error          : sticky out-of-field flag (macro builds only)
module poseidon_word_packer #(
    parameter int HOST_W = 64,
    parameter int ELEM_W = 256,
    parameter int WORDS  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_host_valid,
    output logic              io_host_ready,
    input  logic              io_host_last,
    input  logic [HOST_W-1:0] io_host_payload,
    output logic              io_output_valid,
    input  logic              io_output_ready,
    output logic              io_output_last,
    output logic [ELEM_W-1:0] io_output_payload
`ifdef POSEIDON_FIELD_CHECK_EN
    ,
    output logic              io_error
`endif
);

    import poseidon_pkg::*;

    packer_state_t     r_state;
    packer_state_t     w_state_next;
    logic [1:0]        r_cnt;
    logic [HOST_W-1:0] r_acc [0:WORDS-2];
    logic              r_last;
    logic [ELEM_W-1:0] r_payload;

    logic              w_host_xfer;
    logic              w_out_xfer;
    logic              w_complete;
    logic [ELEM_W-1:0] w_elem;

    assign io_output_valid   = (r_state == OFFER);
    assign io_output_last    = r_last;
    assign io_output_payload = r_payload;

    // Ready only looks at the output side, so a held beat blocks the host.
    assign io_host_ready = !io_output_valid || io_output_ready;
    assign w_host_xfer   = io_host_valid && io_host_ready;
    assign w_out_xfer    = io_output_valid && io_output_ready;
    assign w_complete    = w_host_xfer && ((r_cnt == 2'(WORDS-1)) || io_host_last);

    // Element assembly: slots below cnt come from the accumulator, slot cnt
    // from the word on the bus, slots above cnt are zero padding.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_slot
            if (gi < WORDS-1) begin : g_acc_slot
                assign w_elem[gi*HOST_W +: HOST_W] =
                    (r_cnt == 2'(gi)) ? io_host_payload :
                    (r_cnt >  2'(gi)) ? r_acc[gi]       : '0;

                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        r_acc[gi] <= '0;
                    end else if (w_complete) begin
                        r_acc[gi] <= '0;
                    end else if (w_host_xfer && (r_cnt == 2'(gi))) begin
                        r_acc[gi] <= io_host_payload;
                    end
                end
            end else begin : g_top_slot
                assign w_elem[gi*HOST_W +: HOST_W] =
                    (r_cnt == 2'(gi)) ? io_host_payload : '0;
            end
        end
    endgenerate

    // Word index counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 2'd0;
        end else if (w_complete) begin
            r_cnt <= 2'd0;
        end else if (w_host_xfer) begin
            r_cnt <= r_cnt + 2'd1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state. A completing word always lands in OFFER, which also covers
    // the back-to-back case where the pending beat leaves on the same edge.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            COLLECT: if (w_complete) w_state_next = OFFER;
            OFFER:   if (w_out_xfer && !w_complete) w_state_next = COLLECT;
            default: w_state_next = COLLECT;
        endcase
    end

    // Output beat register; only reloaded by a completing word, so it is
    // naturally held while the core stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last    <= 1'b0;
            r_payload <= '0;
        end else if (w_complete) begin
            r_last    <= io_host_last;
            r_payload <= w_elem;
        end
    end

`ifdef POSEIDON_FIELD_CHECK_EN
    logic w_ge;
    logic r_error;

    poseidon_modulus_check u_modulus_check (
        .i_elem (w_elem),
        .o_ge   (w_ge)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_error <= 1'b0;
        end else if (w_complete && w_ge) begin
            r_error <= 1'b1;
        end
    end

    assign io_error = r_error;
`endif

endmodule

// File: tb/tb_poseidon_word_packer.sv
// Directed testbench for poseidon_word_packer. Inputs are driven and
// outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_poseidon_word_packer;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         io_host_valid = 1'b0;
    logic         io_host_ready;
    logic         io_host_last = 1'b0;
    logic [63:0]  io_host_payload = '0;
    logic         io_output_valid;
    logic         io_output_ready = 1'b1;
    logic         io_output_last;
    logic [255:0] io_output_payload;
`ifdef POSEIDON_FIELD_CHECK_EN
    logic         io_error;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int cyc1  = 0;
    int cyc2  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    poseidon_word_packer dut (
        .clk               (clk),
        .reset             (reset),
        .io_host_valid     (io_host_valid),
        .io_host_ready     (io_host_ready),
        .io_host_last      (io_host_last),
        .io_host_payload   (io_host_payload),
        .io_output_valid   (io_output_valid),
        .io_output_ready   (io_output_ready),
        .io_output_last    (io_output_last),
        .io_output_payload (io_output_payload)
`ifdef POSEIDON_FIELD_CHECK_EN
        ,
        .io_error          (io_error)
`endif
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one host word at the current falling edge and return at the
    // next falling edge, after the rising edge that accepted it. Valid is
    // left high so consecutive calls stream one word per cycle.
    task automatic put(input logic [63:0] w, input logic l);
        int budget;
        io_host_valid   = 1'b1;
        io_host_payload = w;
        io_host_last    = l;
        budget = 0;
        while (io_host_ready !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        chk($sformatf("host_ready word %h", w), {255'd0, io_host_ready}, 256'd1);
        @(negedge clk);
        $display("host word %h last=%0b accepted at cycle %0d", w, l, cyc);
    endtask

    task automatic idle();
        io_host_valid   = 1'b0;
        io_host_last    = 1'b0;
        io_host_payload = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("reset valid",   {255'd0, io_output_valid}, 256'd0);
        chk("reset last",    {255'd0, io_output_last},  256'd0);
        chk("reset payload", io_output_payload,         256'd0);
        chk("reset ready",   {255'd0, io_host_ready},   256'd1);
        reset = 1'b1;
        @(negedge clk);

        // 4-word message
        io_output_ready = 1'b1;
        put(64'h1, 1'b0);
        put(64'h2, 1'b0);
        put(64'h3, 1'b0);
        put(64'h4, 1'b1);
        chk("t1 valid",   {255'd0, io_output_valid}, 256'd1);
        chk("t1 last",    {255'd0, io_output_last},  256'd1);
        chk("t1 payload", io_output_payload, {64'h4, 64'h3, 64'h2, 64'h1});
        $display("beat payload %h last=%0b", io_output_payload, io_output_last);
        idle();
        @(negedge clk);
        chk("t1 valid drop", {255'd0, io_output_valid}, 256'd0);

        // 6-word message, padded second beat
        put(64'hA, 1'b0);
        put(64'hB, 1'b0);
        put(64'hC, 1'b0);
        put(64'hD, 1'b0);
        chk("t2 b1 valid",   {255'd0, io_output_valid}, 256'd1);
        chk("t2 b1 last",    {255'd0, io_output_last},  256'd0);
        chk("t2 b1 payload", io_output_payload, {64'hD, 64'hC, 64'hB, 64'hA});
        put(64'hE, 1'b0);
        chk("t2 gap valid",  {255'd0, io_output_valid}, 256'd0);
        put(64'hF, 1'b1);
        chk("t2 b2 valid",   {255'd0, io_output_valid}, 256'd1);
        chk("t2 b2 last",    {255'd0, io_output_last},  256'd1);
        chk("t2 b2 payload", io_output_payload, {64'h0, 64'h0, 64'hF, 64'hE});
        idle();
        @(negedge clk);
        chk("t2 valid drop", {255'd0, io_output_valid}, 256'd0);

        // Downstream stall with a beat pending, then back-to-back release
        io_output_ready = 1'b0;
        put(64'h11, 1'b0);
        put(64'h12, 1'b0);
        put(64'h13, 1'b0);
        put(64'h14, 1'b0);
        io_host_valid   = 1'b1;
        io_host_payload = 64'h15;
        io_host_last    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3 stall%0d ready", i),   {255'd0, io_host_ready},   256'd0);
            chk($sformatf("t3 stall%0d valid", i),   {255'd0, io_output_valid}, 256'd1);
            chk($sformatf("t3 stall%0d last", i),    {255'd0, io_output_last},  256'd0);
            chk($sformatf("t3 stall%0d payload", i), io_output_payload,
                {64'h14, 64'h13, 64'h12, 64'h11});
            @(negedge clk);
        end
        io_output_ready = 1'b1;
        @(negedge clk);
        chk("t3 b2b valid",   {255'd0, io_output_valid}, 256'd1);
        chk("t3 b2b last",    {255'd0, io_output_last},  256'd1);
        chk("t3 b2b payload", io_output_payload, {64'h0, 64'h0, 64'h0, 64'h15});
        idle();
        @(negedge clk);
        chk("t3 valid drop", {255'd0, io_output_valid}, 256'd0);

        // 8 words streamed continuously
        put(64'h21, 1'b0);
        put(64'h22, 1'b0);
        put(64'h23, 1'b0);
        put(64'h24, 1'b0);
        cyc1 = cyc;
        chk("t4 b1 valid",   {255'd0, io_output_valid}, 256'd1);
        chk("t4 b1 last",    {255'd0, io_output_last},  256'd0);
        chk("t4 b1 payload", io_output_payload, {64'h24, 64'h23, 64'h22, 64'h21});
        put(64'h25, 1'b0);
        put(64'h26, 1'b0);
        put(64'h27, 1'b0);
        put(64'h28, 1'b1);
        cyc2 = cyc;
        chk("t4 b2 valid",   {255'd0, io_output_valid}, 256'd1);
        chk("t4 b2 last",    {255'd0, io_output_last},  256'd1);
        chk("t4 b2 payload", io_output_payload, {64'h28, 64'h27, 64'h26, 64'h25});
        chk("t4 beat spacing", 256'(cyc2 - cyc1), 256'd4);
        idle();
        @(negedge clk);

        // Reset mid-message discards the partial element
        put(64'h31, 1'b0);
        put(64'h32, 1'b0);
        idle();
        reset = 1'b0;
        #1;
        chk("t5 rst valid",   {255'd0, io_output_valid}, 256'd0);
        chk("t5 rst last",    {255'd0, io_output_last},  256'd0);
        chk("t5 rst payload", io_output_payload,         256'd0);
        chk("t5 rst ready",   {255'd0, io_host_ready},   256'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        put(64'h41, 1'b0);
        put(64'h42, 1'b0);
        put(64'h43, 1'b0);
        put(64'h44, 1'b1);
        chk("t5 valid",   {255'd0, io_output_valid}, 256'd1);
        chk("t5 last",    {255'd0, io_output_last},  256'd1);
        chk("t5 payload", io_output_payload, {64'h44, 64'h43, 64'h42, 64'h41});
        idle();
        @(negedge clk);

`ifdef POSEIDON_FIELD_CHECK_EN
        // modulus - 1 is in field
        put(64'hffffffff00000000, 1'b0);
        put(64'h53bda402fffe5bfe, 1'b0);
        put(64'h3339d80809a1d805, 1'b0);
        put(64'h73eda753299d7d48, 1'b1);
        chk("t6 m-1 error", {255'd0, io_error}, 256'd0);
        chk("t6 m-1 payload", io_output_payload,
            256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000000);
        idle();
        @(negedge clk);
        // modulus itself is out of field, still forwarded
        put(64'hffffffff00000001, 1'b0);
        put(64'h53bda402fffe5bfe, 1'b0);
        put(64'h3339d80809a1d805, 1'b0);
        put(64'h73eda753299d7d48, 1'b1);
        chk("t6 m error", {255'd0, io_error}, 256'd1);
        chk("t6 m valid", {255'd0, io_output_valid}, 256'd1);
        chk("t6 m payload", io_output_payload,
            256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001);
        idle();
        repeat (2) @(negedge clk);
        chk("t6 error sticky", {255'd0, io_error}, 256'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
